// File: rtl/spi_opcode_dispatcher.sv
`default_nettype none
// ============================================================================
// spi_opcode_dispatcher
// Decodes SPI opcodes to one of three targets, turns level valids into strobes
// and returns the selected target's response. Revision: 1.0
// ============================================================================
module spi_opcode_dispatcher #(
  parameter logic [7:0] T0_BASE           = 8'h10,
  parameter logic [7:0] T0_MASK           = 8'hF0,
  parameter logic [7:0] T1_BASE           = 8'h20,
  parameter logic [7:0] T1_MASK           = 8'hF0,
  parameter logic [7:0] T2_BASE           = 8'hD0,
  parameter logic [7:0] T2_MASK           = 8'hF0,
  parameter logic [7:0] UNMAPPED_RESPONSE = 8'hFF
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic [7:0]  opcode_in,
  input  logic        opcode_valid_in,
  input  logic [7:0]  operand_in,
  input  logic        operand_valid_in,
  output logic [7:0]  response_out,
  output logic        response_valid_out,
  output logic [2:0]  target_select_out,
  output logic [7:0]  target_opcode_out,
  output logic [2:0]  target_start_out,
  output logic [7:0]  target_operand_out,
  output logic [2:0]  target_operand_strobe_out,
  output logic [7:0]  target_operand_index_out,
  output logic [2:0]  target_done_out,
  input  logic [23:0] target_response_in,
  input  logic [2:0]  target_response_valid_in,
  output logic [7:0]  unmapped_count_out
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_UNMAPPED = 3'd3,
    ST_CLOSE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        opcode_valid_prev_q, operand_valid_prev_q;
  logic [7:0]  opcode_q, opcode_d;
  logic [2:0]  select_q, select_d;
  logic [2:0]  start_q, start_d;
  logic [7:0]  operand_q, operand_d;
  logic [2:0]  strobe_q, strobe_d;
  logic [7:0]  index_q, index_d;
  logic [2:0]  done_q, done_d;
  logic [7:0]  resp_q, resp_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  unmapped_q, unmapped_d;

  logic        opcode_rise, opcode_fall, operand_rise;
  logic [2:0]  match_onehot;
  logic [7:0]  sel_byte;
  logic        sel_valid;

  assign opcode_rise  = opcode_valid_in & ~opcode_valid_prev_q;
  assign opcode_fall  = ~opcode_valid_in & opcode_valid_prev_q;
  assign operand_rise = operand_valid_in & ~operand_valid_prev_q;

  // Priority order gives the lowest-indexed target the win on overlapping windows
  always_comb begin
    match_onehot = 3'b000;
    if ((opcode_q & T0_MASK) == T0_BASE) begin
      match_onehot = 3'b001;
    end else if ((opcode_q & T1_MASK) == T1_BASE) begin
      match_onehot = 3'b010;
    end else if ((opcode_q & T2_MASK) == T2_BASE) begin
      match_onehot = 3'b100;
    end
  end

  always_comb begin
    sel_byte  = 8'h00;
    sel_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (select_q[k]) begin
        sel_byte  = target_response_in[8*k +: 8];
        sel_valid = target_response_valid_in[k];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    select_d     = select_q;
    start_d      = 3'b000;
    operand_d    = operand_q;
    strobe_d     = 3'b000;
    index_d      = index_q;
    done_d       = 3'b000;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    unmapped_d   = unmapped_q;

    case (state_q)
      ST_IDLE: begin
        if (opcode_rise) begin
          opcode_d = opcode_in;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        select_d = match_onehot;
        start_d  = match_onehot;
        if (match_onehot == 3'b000) begin
          if (unmapped_q != 8'hFF) unmapped_d = unmapped_q + 8'd1;
          resp_d       = UNMAPPED_RESPONSE;
          resp_valid_d = 1'b1;
        end
        // A chip-select release during decode still yields a done pulse
        if (!opcode_valid_in) begin
          done_d  = match_onehot;
          state_d = ST_CLOSE;
        end else begin
          state_d = (match_onehot == 3'b000) ? ST_UNMAPPED : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        resp_valid_d = sel_valid;
        resp_d       = sel_valid ? sel_byte : 8'h00;
        if ((strobe_q != 3'b000) && (index_q != 8'hFF)) index_d = index_q + 8'd1;
        if (operand_rise) begin
          operand_d = operand_in;
          strobe_d  = select_q;
        end
        if (opcode_fall) begin
          done_d  = select_q;
          state_d = ST_CLOSE;
        end
      end
      ST_UNMAPPED: begin
        if (opcode_fall) state_d = ST_CLOSE;
      end
      ST_CLOSE: begin
        select_d     = 3'b000;
        resp_d       = 8'h00;
        resp_valid_d = 1'b0;
        index_d      = 8'h00;
        if (opcode_rise) begin
          opcode_d = opcode_in;
          state_d  = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q              <= ST_IDLE;
      opcode_valid_prev_q  <= 1'b0;
      operand_valid_prev_q <= 1'b0;
      opcode_q             <= 8'h00;
      select_q             <= 3'b000;
      start_q              <= 3'b000;
      operand_q            <= 8'h00;
      strobe_q             <= 3'b000;
      index_q              <= 8'h00;
      done_q               <= 3'b000;
      resp_q               <= 8'h00;
      resp_valid_q         <= 1'b0;
      unmapped_q           <= 8'h00;
    end else begin
      state_q              <= state_d;
      opcode_valid_prev_q  <= opcode_valid_in;
      operand_valid_prev_q <= operand_valid_in;
      opcode_q             <= opcode_d;
      select_q             <= select_d;
      start_q              <= start_d;
      operand_q            <= operand_d;
      strobe_q             <= strobe_d;
      index_q              <= index_d;
      done_q               <= done_d;
      resp_q               <= resp_d;
      resp_valid_q         <= resp_valid_d;
      unmapped_q           <= unmapped_d;
    end
  end

  assign response_out              = resp_q;
  assign response_valid_out        = resp_valid_q;
  assign target_select_out         = select_q;
  assign target_opcode_out         = opcode_q;
  assign target_start_out          = start_q;
  assign target_operand_out        = operand_q;
  assign target_operand_strobe_out = strobe_q;
  assign target_operand_index_out  = index_q;
  assign target_done_out           = done_q;
  assign unmapped_count_out        = unmapped_q;

endmodule
`default_nettype wire
